pc_redirect_unit: RTL and testbench

Fetch-side next-PC generator and branch-resolution tracker. It sits directly downstream of the branch predictor and consumes its per-PC `taken`/`target` prediction. It records each fetched instruction's prediction in a small in-order queue and checks that prediction against the EXE-stage outcome. On a mismatch it redirects fetch, flushes the front end, and drives the actual-outcome bit back into the predictor's history/pattern tables.

---
 rtl/pc_redirect_unit.sv | 101 ++++++++++
 tb/tb_pc_redirect_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_redirect_unit.sv
// Fetch-side next-PC generator with an in-order prediction queue that checks
// each fetched instruction's branch prediction against its EXE-stage outcome.
module pc_redirect_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        stall,
  input  logic        bp_taken,
  input  logic [31:0] bp_target,
  output logic [31:0] pc,
  output logic        fetch_valid,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        ex_is_cti,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  output logic        pcbranch,
  output logic        mispredict,
  output logic        flush,
  output logic        q_err,
  output logic [31:0] br_cnt,
  output logic [31:0] mp_cnt
);

  localparam int AW = $clog2(QDEPTH);

  logic [AW:0]   wptr, rptr;
  logic          q_taken  [QDEPTH];
  logic [31:0]   q_target [QDEPTH];

  logic          empty, full, act, push, pop;
  logic          h_taken;
  logic [31:0]   h_target;
  logic [31:0]   redirect_pc;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

  assign h_taken  = q_taken[rptr[AW-1:0]];
  assign h_target = q_target[rptr[AW-1:0]];

  assign act         = ex_is_cti & ex_taken;
  assign pcbranch    = ex_valid & ex_is_cti & ex_taken;
  assign mispredict  = ex_valid & ~empty &
                       ((h_taken ^ act) | (act & (h_target != ex_target)));
  assign redirect_pc = act ? ex_target : ex_pc + 32'd4;

  // A pop in the same cycle frees the slot, so a full queue can still accept a push.
  assign fetch_valid = ~stall & ~(full & ~ex_valid) & ~flush & ~mispredict;

  assign push = fetch_valid;
  assign pop  = ex_valid & ~empty;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc     <= RESET_PC;
      wptr   <= '0;
      rptr   <= '0;
      flush  <= 1'b0;
      q_err  <= 1'b0;
      br_cnt <= '0;
      mp_cnt <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        q_taken[i]  <= 1'b0;
        q_target[i] <= '0;
      end
    end else begin
      flush <= mispredict;

      if (ex_valid && empty)
        q_err <= 1'b1;

      if (pop && ex_is_cti)
        br_cnt <= br_cnt + 32'd1;
      if (mispredict)
        mp_cnt <= mp_cnt + 32'd1;

      if (mispredict)
        pc <= redirect_pc;
      else if (fetch_valid)
        pc <= bp_taken ? bp_target : pc + 32'd4;

      // Redirect discards the in-flight push and pop and empties the queue.
      if (mispredict) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (push) begin
          q_taken[wptr[AW-1:0]]  <= bp_taken;
          q_target[wptr[AW-1:0]] <= bp_target;
          wptr <= wptr + (AW+1)'(1);
        end
        if (pop)
          rptr <= rptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed-vector bench for pc_redirect_unit with hand-computed expectations.
module tb_pc_redirect_unit;

  logic        clk = 1'b0;
  logic        rstn;
  logic        stall;
  logic        bp_taken;
  logic [31:0] bp_target;
  logic [31:0] pc;
  logic        fetch_valid;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_is_cti;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        pcbranch;
  logic        mispredict;
  logic        flush;
  logic        q_err;
  logic [31:0] br_cnt;
  logic [31:0] mp_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  pc_redirect_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(4)) dut (
    .clk(clk), .rstn(rstn), .stall(stall),
    .bp_taken(bp_taken), .bp_target(bp_target),
    .pc(pc), .fetch_valid(fetch_valid),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_is_cti(ex_is_cti),
    .ex_taken(ex_taken), .ex_target(ex_target),
    .pcbranch(pcbranch), .mispredict(mispredict), .flush(flush),
    .q_err(q_err), .br_cnt(br_cnt), .mp_cnt(mp_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic [31:0] epc, input logic cti,
                        input logic tk, input logic [31:0] tgt);
    ex_valid  = v;
    ex_pc     = epc;
    ex_is_cti = cti;
    ex_taken  = tk;
    ex_target = tgt;
  endtask

  initial begin
    rstn = 1'b0; stall = 1'b0; bp_taken = 1'b0; bp_target = '0;
    set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #12 rstn = 1'b1;
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_flush", {31'b0, flush}, 32'h0);
    chk("rst_qerr", {31'b0, q_err}, 32'h0);
    chk("rst_br", br_cnt, 32'h0);
    chk("rst_mp", mp_cnt, 32'h0);
    chk("rst_fv", {31'b0, fetch_valid}, 32'h1);

    // Sequential fetch fills the 4-entry queue
    for (int i = 0; i < 4; i++) begin
      chk("fill_pc", pc, 32'(4 * i));
      chk("fill_fv", {31'b0, fetch_valid}, 32'h1);
      cyc();
    end
    chk("full_pc", pc, 32'h10);
    chk("full_fv", {31'b0, fetch_valid}, 32'h0);
    cyc();
    chk("full_hold", pc, 32'h10);

    // Full queue: simultaneous push and correct pop
    set_ex(1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    chk("pp_fv", {31'b0, fetch_valid}, 32'h1);
    chk("pp_mp", {31'b0, mispredict}, 32'h0);
    cyc();
    chk("pp_pc", pc, 32'h14);
    ex_valid = 1'b0;
    #1;
    chk("pp_still_full", {31'b0, fetch_valid}, 32'h0);

    // Correct not-taken branch under stall
    stall = 1'b1;
    set_ex(1'b1, 32'h4, 1'b1, 1'b0, 32'h0);
    #1;
    chk("nt_mp", {31'b0, mispredict}, 32'h0);
    chk("nt_pcbranch", {31'b0, pcbranch}, 32'h0);
    cyc();
    chk("nt_br", br_cnt, 32'h1);
    chk("nt_pc_hold", pc, 32'h14);

    // Predicted not-taken, resolves taken to 0x100; overrides stall
    set_ex(1'b1, 32'h8, 1'b1, 1'b1, 32'h100);
    #1;
    chk("mp1_mp", {31'b0, mispredict}, 32'h1);
    chk("mp1_pcbranch", {31'b0, pcbranch}, 32'h1);
    chk("mp1_fv", {31'b0, fetch_valid}, 32'h0);
    cyc();
    chk("mp1_pc", pc, 32'h100);
    chk("mp1_flush", {31'b0, flush}, 32'h1);
    chk("mp1_mpcnt", mp_cnt, 32'h1);
    chk("mp1_br", br_cnt, 32'h2);
    stall = 1'b0;
    ex_valid = 1'b0;
    #1;
    chk("mp1_flush_fv", {31'b0, fetch_valid}, 32'h0);
    cyc();
    chk("mp1_flush_end", {31'b0, flush}, 32'h0);
    chk("mp1_pc_hold", pc, 32'h100);
    chk("mp1_push_fv", {31'b0, fetch_valid}, 32'h1);

    // Predicted taken fetch at 0x100 -> 0x40
    bp_taken = 1'b1; bp_target = 32'h40;
    cyc();
    chk("bp_pc", pc, 32'h40);

    // Correct taken resolution of 0x100
    bp_taken = 1'b0; bp_target = 32'h0;
    set_ex(1'b1, 32'h100, 1'b1, 1'b1, 32'h40);
    #1;
    chk("ok_mp", {31'b0, mispredict}, 32'h0);
    chk("ok_pcbranch", {31'b0, pcbranch}, 32'h1);
    cyc();
    chk("ok_pc", pc, 32'h44);
    chk("ok_br", br_cnt, 32'h3);

    // Push predicted-taken 0x44 -> 0x80; pop correct non-CTI 0x40
    bp_taken = 1'b1; bp_target = 32'h80;
    set_ex(1'b1, 32'h40, 1'b0, 1'b0, 32'h0);
    #1;
    chk("nc_mp", {31'b0, mispredict}, 32'h0);
    cyc();
    chk("nc_pc", pc, 32'h80);
    chk("nc_br", br_cnt, 32'h3);

    // Predicted taken to 0x80, actual taken to 0x90
    bp_taken = 1'b0; stall = 1'b1;
    set_ex(1'b1, 32'h44, 1'b1, 1'b1, 32'h90);
    #1;
    chk("tgt_mp", {31'b0, mispredict}, 32'h1);
    cyc();
    chk("tgt_pc", pc, 32'h90);
    chk("tgt_flush", {31'b0, flush}, 32'h1);
    chk("tgt_mpcnt", mp_cnt, 32'h2);
    chk("tgt_br", br_cnt, 32'h4);
    stall = 1'b0; ex_valid = 1'b0;
    cyc();
    chk("tgt_pc_hold", pc, 32'h90);

    // Build a taken prediction at 0x20 (BTB alias on a non-CTI)
    bp_taken = 1'b1; bp_target = 32'h20;
    cyc();
    chk("al_pc0", pc, 32'h20);
    bp_target = 32'h60;
    set_ex(1'b1, 32'h90, 1'b1, 1'b1, 32'h20);
    #1;
    chk("al_ok_mp", {31'b0, mispredict}, 32'h0);
    cyc();
    chk("al_pc1", pc, 32'h60);
    chk("al_br", br_cnt, 32'h5);
    bp_taken = 1'b0; stall = 1'b1;
    set_ex(1'b1, 32'h20, 1'b0, 1'b1, 32'h999);
    #1;
    chk("al_mp", {31'b0, mispredict}, 32'h1);
    chk("al_pcbranch", {31'b0, pcbranch}, 32'h0);
    cyc();
    chk("al_pc", pc, 32'h24);
    chk("al_mpcnt", mp_cnt, 32'h3);
    chk("al_br_same", br_cnt, 32'h5);
    ex_valid = 1'b0;
    cyc();
    chk("al_flush_end", {31'b0, flush}, 32'h0);

    // Pop on empty queue
    set_ex(1'b1, 32'h30, 1'b1, 1'b1, 32'h500);
    #1;
    chk("qe_mp", {31'b0, mispredict}, 32'h0);
    cyc();
    chk("qe_qerr", {31'b0, q_err}, 32'h1);
    chk("qe_br", br_cnt, 32'h5);
    chk("qe_mpcnt", mp_cnt, 32'h3);
    chk("qe_pc", pc, 32'h24);
    ex_valid = 1'b0;
    cyc();
    chk("qe_sticky", {31'b0, q_err}, 32'h1);

    // Asynchronous reset mid-stream
    stall = 1'b0;
    cyc();
    chk("pre_rst_pc", pc, 32'h28);
    #2 rstn = 1'b0;
    #1;
    chk("ar_pc", pc, 32'h0);
    chk("ar_qerr", {31'b0, q_err}, 32'h0);
    chk("ar_br", br_cnt, 32'h0);
    chk("ar_mp", mp_cnt, 32'h0);
    #2 rstn = 1'b1;
    #1;
    chk("ar_fv", {31'b0, fetch_valid}, 32'h1);
    cyc();
    chk("ar_step", pc, 32'h4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
